// File: rtl/pixel_feeder_pkg.sv
// rtl/pixel_feeder_pkg.sv - frame geometry defaults and FSM state encoding
// Shared by the feeder top and its frame counter.
package pixel_feeder_pkg;

   localparam int DEPTH_DEF      = 410;
   localparam int WIDTH_DEF      = 361;
   localparam int FRAME_SIZE_DEF = DEPTH_DEF * WIDTH_DEF;
   localparam int ADDR_W_DEF     = 18;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      LOAD_DRAIN = 3'd2,
      PROCESS    = 3'd3,
      FLUSH      = 3'd4,
      DONE       = 3'd5
   } state_t;

endpackage

// File: rtl/frame_counter.sv
// rtl/frame_counter.sv - saturating frame index counter with terminal-count flag
// Holds at FRAME_SIZE-1 so an index is never reissued within a frame.
module frame_counter
   import pixel_feeder_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FRAME_SIZE = FRAME_SIZE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              inc,
   output logic [ADDR_W-1:0] count,
   output logic              last
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_SIZE - 1);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (inc && !last) begin
         count <= count + ADDR_W'(1);
      end
   end

   assign last = (count == LAST_IDX);

endmodule

// File: rtl/pixel_feeder.sv
// rtl/pixel_feeder.sv - streams a frame from memory into a filter, then collects its results
// Load phase feeds every pixel with enable; process phase pulls one result per enable_process.
module pixel_feeder
   import pixel_feeder_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic [7:0]        image_output,
   output logic              enable,
   output logic              enable_process,
   input  logic [7:0]        result_in,
   output logic [7:0]        result_data,
   output logic [ADDR_W-1:0] result_addr,
   output logic              result_valid,
   output logic              busy,
   output logic              done
);

   localparam int FRAME_SIZE = DEPTH * WIDTH;

   state_t              state;
   state_t              state_next;
   logic                count_clear;
   logic                rd_issue;
   logic                rd_pend;
   logic                rd_last;
   logic [ADDR_W-1:0]   rd_count;
   logic                proc_last;
   logic [ADDR_W-1:0]   proc_count;
   logic                cap_pend;
   logic [ADDR_W-1:0]   cap_addr;

   frame_counter #(
      .ADDR_W     (ADDR_W),
      .FRAME_SIZE (FRAME_SIZE)
   ) u_rd_counter (
      .clk   (clk),
      .rst   (rst),
      .clear (count_clear),
      .inc   (rd_issue),
      .count (rd_count),
      .last  (rd_last)
   );

   frame_counter #(
      .ADDR_W     (ADDR_W),
      .FRAME_SIZE (FRAME_SIZE)
   ) u_proc_counter (
      .clk   (clk),
      .rst   (rst),
      .clear (count_clear),
      .inc   (enable_process),
      .count (proc_count),
      .last  (proc_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      count_clear    = 1'b0;
      rd_issue       = 1'b0;
      enable_process = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next  = LOAD;
               count_clear = 1'b1;
            end
         end
         LOAD: begin
            if (!stall) begin
               rd_issue = 1'b1;
               if (rd_last) begin
                  state_next = LOAD_DRAIN;
               end
            end
         end
         // The final read returns during this cycle; its enable beat is emitted here.
         LOAD_DRAIN: begin
            state_next = PROCESS;
         end
         PROCESS: begin
            if (!stall) begin
               enable_process = 1'b1;
               if (proc_last) begin
                  state_next = FLUSH;
               end
            end
         end
         // Leave once the capture stage is empty: the last result_valid is on the output now.
         FLUSH: begin
            if (!cap_pend) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next  = IDLE;
            count_clear = 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend      <= 1'b0;
         cap_pend     <= 1'b0;
         cap_addr     <= '0;
         result_valid <= 1'b0;
         result_data  <= '0;
         result_addr  <= '0;
      end else begin
         rd_pend      <= rd_issue;
         cap_pend     <= enable_process;
         cap_addr     <= proc_count;
         result_valid <= cap_pend;
         if (cap_pend) begin
            result_data <= result_in;
            result_addr <= cap_addr;
         end
      end
   end

   assign mem_addr     = rd_count;
   assign enable       = rd_pend;
   assign image_output = rd_pend ? mem_data : 8'h00;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);

endmodule

// File: tb/tb_pixel_feeder.sv
// tb/tb_pixel_feeder.sv - directed and randomized checks of pixel_feeder against a frame-level model
// Memory and filter are behavioural; expectations come from per-frame pixel and result tables.
module tb_pixel_feeder;

   localparam int N = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic [3:0] mem_addr;
   logic [7:0] mem_data = 8'h00;
   logic [7:0] image_output;
   logic       enable;
   logic       enable_process;
   logic [7:0] result_in = 8'h00;
   logic [7:0] result_data;
   logic [3:0] result_addr;
   logic       result_valid;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   pixel_feeder #(
      .DEPTH  (4),
      .WIDTH  (3),
      .ADDR_W (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .stall          (stall),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .image_output   (image_output),
      .enable         (enable),
      .enable_process (enable_process),
      .result_in      (result_in),
      .result_data    (result_data),
      .result_addr    (result_addr),
      .result_valid   (result_valid),
      .busy           (busy),
      .done           (done)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] mem  [N];
   logic [7:0] filt [N];
   int         fidx = 0;

   // Source memory with one-cycle read latency; filter returns filt[k] for its k-th process beat.
   always @(posedge clk) begin
      mem_data <= (int'(mem_addr) < N) ? mem[mem_addr] : 8'h00;
      if (rst || done) begin
         fidx <= 0;
      end else if (enable_process) begin
         result_in <= (fidx < N) ? filt[fidx] : 8'hEE;
         fidx      <= fidx + 1;
      end
   end

   logic [7:0] en_v [$];
   int         en_c [$];
   int         ep_c [$];
   int         rc   [$];
   int         ra   [$];
   logic [7:0] rdv  [$];
   int         done_n  = 0;
   int         done_c  = 0;
   int         overlap = 0;
   int         cyc     = 0;

   always @(negedge clk) begin
      cyc++;
      if (enable) begin
         en_v.push_back(image_output);
         en_c.push_back(cyc);
      end
      if (enable_process) ep_c.push_back(cyc);
      if (result_valid) begin
         rc.push_back(cyc);
         ra.push_back(int'(result_addr));
         rdv.push_back(result_data);
      end
      if (done) begin
         done_n++;
         done_c = cyc;
      end
      if (enable && enable_process) overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_log();
      en_v.delete(); en_c.delete(); ep_c.delete();
      rc.delete(); ra.delete(); rdv.delete();
      done_n = 0; done_c = 0; overlap = 0;
   endtask

   task automatic pulse_start(output int sc);
      step();
      start = 1'b1;
      sc = cyc + 1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done();
      int b = 0;
      while (done_n == 0 && b < 400) begin
         @(negedge clk);
         b++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_zero(input string ft);
      chk({ft, " mem_addr"}, mem_addr, 0);
      chk({ft, " image_output"}, image_output, 0);
      chk({ft, " enable"}, enable, 0);
      chk({ft, " enable_process"}, enable_process, 0);
      chk({ft, " result_data"}, result_data, 0);
      chk({ft, " result_addr"}, result_addr, 0);
      chk({ft, " result_valid"}, result_valid, 0);
      chk({ft, " busy"}, busy, 0);
      chk({ft, " done"}, done, 0);
   endtask

   task automatic verify_frame(input string ft, input bit timed, input int sc);
      chk({ft, " enable_beats"}, en_v.size(), N);
      chk({ft, " process_beats"}, ep_c.size(), N);
      chk({ft, " results"}, rc.size(), N);
      chk({ft, " done_pulses"}, done_n, 1);
      chk({ft, " overlap"}, overlap, 0);
      chk({ft, " idle_after"}, busy, 0);
      for (int k = 0; k < N && k < en_v.size(); k++)
         chk($sformatf("%s pixel[%0d]", ft, k), en_v[k], mem[k]);
      for (int k = 0; k < N && k < rc.size(); k++) begin
         chk($sformatf("%s result_addr[%0d]", ft, k), ra[k], k);
         chk($sformatf("%s result_data[%0d]", ft, k), rdv[k], filt[k]);
         if (k < ep_c.size())
            chk($sformatf("%s result_lat[%0d]", ft, k), rc[k] - ep_c[k], 2);
      end
      if (rc.size() == N) chk({ft, " done_lat"}, done_c - rc[N-1], 1);
      if (timed && en_c.size() == N && ep_c.size() == N) begin
         chk({ft, " first_enable"}, en_c[0] - sc, 2);
         for (int k = 1; k < N; k++) begin
            chk($sformatf("%s enable_cyc[%0d]", ft, k), en_c[k] - en_c[0], k);
            chk($sformatf("%s process_cyc[%0d]", ft, k), ep_c[k] - ep_c[0], k);
         end
         chk({ft, " first_process"}, ep_c[0] - en_c[N-1], 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int sc;
      int b;

      // Reset state
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check_zero("reset");

      // Plain frame: pixel[i]=i*10, filter returns 200+i
      for (int i = 0; i < N; i++) begin
         mem[i]  = 8'(i * 10);
         filt[i] = 8'(200 + i);
      end
      clr_log();
      pulse_start(sc);
      wait_done();
      verify_frame("plain", 1'b1, sc);

      // Stall for 3 cycles right after address 5 is issued
      for (int i = 0; i < N; i++) filt[i] = 8'($urandom);
      clr_log();
      pulse_start(sc);
      b = 0;
      while (!(busy && mem_addr == 4'd5) && b < 100) begin
         @(negedge clk);
         b++;
      end
      step();
      stall = 1'b1;
      repeat (3) step();
      stall = 1'b0;
      wait_done();
      verify_frame("load_stall", 1'b0, sc);
      if (en_c.size() == N) begin
         chk("load_stall gap", en_c[6] - en_c[5], 4);
         chk("load_stall beat6", en_v[6], 60);
      end

      // Stall for 4 cycles right after process beat 7
      for (int i = 0; i < N; i++) begin
         mem[i]  = 8'($urandom);
         filt[i] = 8'($urandom);
      end
      clr_log();
      pulse_start(sc);
      b = 0;
      while (!(enable_process && fidx == 7) && b < 100) begin
         @(negedge clk);
         b++;
      end
      step();
      stall = 1'b1;
      repeat (4) step();
      stall = 1'b0;
      wait_done();
      verify_frame("proc_stall", 1'b0, sc);
      if (ep_c.size() == N) chk("proc_stall gap", ep_c[8] - ep_c[7], 5);

      // Reset on the 3rd process beat, with start asserted alongside
      clr_log();
      pulse_start(sc);
      b = 0;
      while (!(enable_process && fidx == 1) && b < 100) begin
         @(negedge clk);
         b++;
      end
      step();
      rst   = 1'b1;
      start = 1'b1;
      step();
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_zero("abort");
      @(negedge clk);
      chk("abort still_idle", busy, 0);
      chk("abort no_done", done_n, 0);
      for (int i = 0; i < N; i++) begin
         mem[i]  = 8'($urandom);
         filt[i] = 8'($urandom);
      end
      clr_log();
      pulse_start(sc);
      wait_done();
      verify_frame("after_abort", 1'b1, sc);

      // Extra start pulses during LOAD and in DONE
      for (int i = 0; i < N; i++) begin
         mem[i]  = 8'($urandom);
         filt[i] = 8'($urandom);
      end
      clr_log();
      pulse_start(sc);
      repeat (3) begin
         start = 1'b1;
         step();
         start = 1'b0;
         step();
      end
      b = 0;
      while (!(result_valid && result_addr == 4'(N - 1)) && b < 200) begin
         @(negedge clk);
         b++;
      end
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      chk("restart busy", busy, 0);
      wait_done();
      verify_frame("restart", 1'b1, sc);

      // Random frames with random stall
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N; i++) begin
            mem[i]  = 8'($urandom);
            filt[i] = 8'($urandom);
         end
         clr_log();
         pulse_start(sc);
         b = 0;
         while (done_n == 0 && b < 400) begin
            stall = ($urandom_range(0, 3) == 0);
            step();
            b++;
         end
         stall = 1'b0;
         repeat (4) @(negedge clk);
         verify_frame($sformatf("random%0d", f), 1'b0, sc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
